trigger_capture: RTL and testbench
==================================

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 512, frame length in samples.
REQ-002 SHALL have parameter WIDTH, default 12, sample width in bits.
REQ-003 SHALL have parameter PRETRIG, default 128, samples kept before the trigger sample; legal range 1..DEPTH-2.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-005 SHALL have: sample_valid  input  1  high for one clk per new ADC sample.
REQ-006 SHALL have: sample  input  WIDTH  unsigned ADC sample, qualified by sample_valid.
REQ-007 SHALL have: trig_level  input  WIDTH  unsigned trigger threshold.
REQ-008 SHALL have: trig_enable  input  1  capture armed while high.
REQ-009 SHALL have: ready  input  1  downstream copier idle; low while it copies.
REQ-010 SHALL have: read  output  1  one-cycle frame-handoff request to downstream.
REQ-011 SHALL have: data  output  WIDTH x [0:DEPTH-1]  captured frame; data[0] is the oldest sample.
REQ-012 SHALL have: busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL hold a DEPTH-entry shift buffer driving data directly; on every sample_valid in PRE, ARMED or POST: data[i] <= data[i+1] for i < DEPTH-1, and data[DEPTH-1] <= sample.
REQ-014 SHALL keep data unchanged in IDLE, HANDOFF, WAIT_LOW and WAIT_HIGH, whatever the value of sample_valid.
REQ-015 SHALL implement states IDLE, PRE, ARMED, POST, HANDOFF, WAIT_LOW and WAIT_HIGH.
REQ-016 SHALL use a counter wide enough to hold DEPTH-1 (9 bits at default), cleared on entry to PRE and POST.
REQ-017 IDLE: when trig_enable=1 -> PRE.
REQ-018 PRE: count valid samples; on the valid sample that makes count = PRETRIG -> ARMED.
REQ-019 SHALL register prev_sample on every shifted valid sample.
REQ-020 ARMED: trigger fires on a valid sample when prev_sample < trig_level and sample >= trig_level; that sample is shifted in as the trigger sample and the state goes to POST.
REQ-021 POST: count valid samples; on the valid sample that makes count = DEPTH-1-PRETRIG (383 at defaults) -> HANDOFF; the trigger sample then sits at data[PRETRIG].
REQ-022 HANDOFF: assert read for exactly one cycle in the first cycle ready=1, then -> WAIT_LOW; read=0 in every other state.
REQ-023 WAIT_LOW: wait for ready=0 -> WAIT_HIGH.
REQ-024 WAIT_HIGH: wait for ready=1 (copy done) -> PRE if trig_enable=1, else -> IDLE.
REQ-025 trig_enable=0 in PRE or ARMED SHALL force IDLE on the next edge; the buffer keeps its contents.
REQ-026 trig_enable=0 in POST or later SHALL NOT abort; the frame SHALL complete and be handed off.
REQ-027 All comparisons SHALL be unsigned over WIDTH bits; trig_level=0 never fires, because prev_sample < 0 is impossible.
REQ-028 A constant input or a falling crossing SHALL NOT fire the trigger.
REQ-029 trig_level changes SHALL take effect on the next valid sample, with no latching.

Reset
REQ-030 rst=1 SHALL asynchronously force: state IDLE, read=0, busy=0, counter=0, prev_sample=0, all data entries=0.
REQ-031 rst asserted in any state, including mid-POST or HANDOFF, SHALL discard the partial frame.
REQ-032 After rst deasserts, capture SHALL restart from IDLE and read no earlier than PRETRIG+1 valid samples after re-entering PRE.

Verification
REQ-033 Ramp 0..4095 step 1, trig_level=1000, PRETRIG=128 -> read pulses once; data[128]=1000, data[0]=872, data[511]=1383.
REQ-034 Constant sample=2000, trig_level=1000 -> state stays ARMED and read never asserts.
REQ-035 trig_enable dropped during ARMED -> IDLE next cycle, busy=0, data frozen; dropped during POST -> frame still completes and read pulses.
REQ-036 ready held 0 when POST completes -> read stays 0 until ready=1, pulses one cycle, and data does not change until ready goes 0 then 1.
REQ-037 rst pulsed mid-POST (between clk edges) -> outputs reset immediately, all data=0, and the next capture is correct.
REQ-038 sample_valid asserted every 3rd cycle -> identical frame content to the back-to-back case; non-valid cycles never shift data.

Source files
------------

// File: rtl/trigger_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : trigger_capture
//  Brief    : Rising-edge level-triggered frame capture. Keeps a DEPTH-sample
//             shift buffer with PRETRIG samples of history ahead of the
//             trigger sample, then hands the frozen frame to a downstream
//             copier with a one-cycle read request and ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module trigger_capture #(
    parameter int DEPTH   = 512,
    parameter int WIDTH   = 12,
    parameter int PRETRIG = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] trig_level,
    input  logic             trig_enable,
    input  logic             ready,
    output logic             read,
    output logic [WIDTH-1:0] data [0:DEPTH-1],
    output logic             busy
);

    // Counter only ever needs to reach DEPTH-1.
    localparam int CW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    // Terminal counts: the counter holds the number of samples already
    // taken in the state, so the last one arrives when it equals N-1.
    localparam logic [CW-1:0] PRE_LAST  = CW'(PRETRIG - 1);
    localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - 2 - PRETRIG);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRE       = 3'd1;
    localparam logic [2:0] S_ARMED     = 3'd2;
    localparam logic [2:0] S_POST      = 3'd3;
    localparam logic [2:0] S_HANDOFF   = 3'd4;
    localparam logic [2:0] S_WAIT_LOW  = 3'd5;
    localparam logic [2:0] S_WAIT_HIGH = 3'd6;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] prev_sample;
    logic             capturing;
    logic             abort;
    logic             shift;
    logic             fire;

    // Buffer moves only while filling; an abort edge freezes it immediately.
    always_comb begin
        capturing = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
        abort     = !trig_enable && ((state == S_PRE) || (state == S_ARMED));
        shift     = sample_valid && capturing && !abort;
        fire      = (prev_sample < trig_level) && (sample >= trig_level);
        read      = (state == S_HANDOFF) && ready;
        busy      = (state != S_IDLE);
    end

    // Next-state decode for the capture/handoff sequence.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (trig_enable) next_state = S_PRE;
            end
            S_PRE: begin
                if (!trig_enable)                   next_state = S_IDLE;
                else if (shift && count == PRE_LAST) next_state = S_ARMED;
            end
            S_ARMED: begin
                if (!trig_enable)       next_state = S_IDLE;
                else if (shift && fire) next_state = S_POST;
            end
            S_POST: begin
                // Disarming here is ignored: a triggered frame always completes.
                if (shift && count == POST_LAST) next_state = S_HANDOFF;
            end
            S_HANDOFF: begin
                if (ready) next_state = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!ready) next_state = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (ready) next_state = trig_enable ? S_PRE : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State, sample counter and previous-sample register for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            count       <= '0;
            prev_sample <= '0;
        end else begin
            state <= next_state;
            if (shift) prev_sample <= sample;
            if ((next_state != state) &&
                ((next_state == S_PRE) || (next_state == S_POST))) begin
                count <= '0;
            end else if (shift && (state != S_ARMED)) begin
                count <= count + 1'b1;
            end
        end
    end

    // Frame buffer: oldest sample at index 0, newest enters at DEPTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) data[i] <= '0;
        end else if (shift) begin
            for (int i = 0; i < DEPTH - 1; i++) data[i] <= data[i+1];
            data[DEPTH-1] <= sample;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trigger_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_trigger_capture
//  Brief    : Self-checking bench for trigger_capture. Expected frames are
//             queued when a capture is started and compared when read pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_trigger_capture;

    localparam int DEPTH   = 512;
    localparam int WIDTH   = 12;
    localparam int PRETRIG = 128;

    logic             clk = 1'b0;
    logic             rst;
    logic             sample_valid;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] trig_level;
    logic             trig_enable;
    logic             ready;
    logic             read;
    logic [WIDTH-1:0] data [0:DEPTH-1];
    logic             busy;

    int n_cmp = 0;
    int n_err = 0;
    int reads_seen = 0;
    int exp_reads  = 0;
    int exp_q[$];

    trigger_capture #(.DEPTH(DEPTH), .WIDTH(WIDTH), .PRETRIG(PRETRIG)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .trig_level   (trig_level),
        .trig_enable  (trig_enable),
        .ready        (ready),
        .read         (read),
        .data         (data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int count_nonzero();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (data[i] != '0) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each read pulse must present a ramp frame data[i] = base+i.
    always @(negedge clk) begin
        if (read === 1'b1) begin
            reads_seen++;
            if (exp_q.size() > 0) begin
                int base;
                int bad;
                base = exp_q.pop_front();
                bad  = 0;
                for (int i = 0; i < DEPTH; i++)
                    if (int'(data[i]) != base + i) bad++;
                check("frame_oldest", int'(data[0]), base);
                check("frame_trigger", int'(data[PRETRIG]), base + PRETRIG);
                check("frame_newest", int'(data[DEPTH-1]), base + DEPTH - 1);
                check("frame_all_bad", bad, 0);
            end
        end
    end

    task automatic send(input int v, input int gap, input bit hold_chk);
        sample_valid = 1'b1;
        sample       = WIDTH'(v);
        tick();
        sample_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            if (hold_chk) check("gap_hold", int'(data[DEPTH-1]), v);
        end
    endtask

    task automatic send_ramp(input int start, input int stop, input int gap,
                             input int drop_at);
        int step;
        step = (stop >= start) ? 1 : -1;
        for (int v = start; v != stop + step; v += step) begin
            if (v == drop_at) trig_enable = 1'b0;
            send(v, gap, (gap > 0) && (v % 100 == 0) && (v <= 1300));
        end
    endtask

    // Downstream copy handshake, then return to IDLE.
    task automatic finish_copy();
        trig_enable = 1'b0;
        ready = 1'b0;
        tick(); tick();
        ready = 1'b1;
        tick(); tick();
        check("idle_after_copy", int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample = '0; trig_level = 12'd1000;
        trig_enable = 1'b0; ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_read", int'(read), 0);
        check("rst_data_nonzero", count_nonzero(), 0);
        @(negedge clk) rst = 1'b0;
        tick();

        // Back-to-back ramp, full range; frame must stay frozen after handoff.
        trig_enable = 1'b1; tick();
        exp_q.push_back(1000 - PRETRIG); exp_reads++;
        send_ramp(0, 4095, 0, -1);
        check("ramp_reads", reads_seen, exp_reads);
        check("ramp_frozen", int'(data[DEPTH-1]), 1383);
        finish_copy();

        // Valid every third cycle: identical frame, no shift on idle cycles.
        trig_enable = 1'b1; tick();
        exp_q.push_back(1000 - PRETRIG); exp_reads++;
        send_ramp(0, 1500, 2, -1);
        check("sparse_reads", reads_seen, exp_reads);
        finish_copy();

        // Constant input above level: stays armed, never fires.
        trig_enable = 1'b1; tick();
        for (int k = 0; k < 600; k++) send(2000, 0, 1'b0);
        check("const_busy", int'(busy), 1);
        check("const_reads", reads_seen, exp_reads);
        trig_enable = 1'b0; tick();
        check("disarm_busy", int'(busy), 0);
        check("disarm_read", int'(read), 0);
        for (int k = 0; k < 4; k++) send(5, 0, 1'b0);
        check("disarm_frozen_new", int'(data[DEPTH-1]), 2000);
        check("disarm_frozen_old", int'(data[0]), 2000);

        // Falling crossing and a zero level must not fire.
        trig_enable = 1'b1; tick();
        send_ramp(3000, 0, 0, -1);
        trig_level = '0;
        send_ramp(0, 700, 0, -1);
        check("nofire_reads", reads_seen, exp_reads);
        trig_enable = 1'b0; tick();
        check("nofire_idle", int'(busy), 0);
        trig_level = 12'd1000;

        // Disarm during POST: frame still completes and is handed off.
        trig_enable = 1'b1; tick();
        exp_q.push_back(1000 - PRETRIG); exp_reads++;
        send_ramp(0, 1500, 0, 1010);
        check("postdrop_reads", reads_seen, exp_reads);
        finish_copy();

        // Copier busy at frame end: read waits for ready, data held.
        trig_enable = 1'b1; tick();
        ready = 1'b0;
        exp_q.push_back(1000 - PRETRIG); exp_reads++;
        send_ramp(0, 1500, 0, -1);
        check("held_read_low", int'(read), 0);
        check("held_busy", int'(busy), 1);
        check("held_no_read", reads_seen, exp_reads - 1);
        ready = 1'b1;
        tick(); tick();
        check("held_one_read", reads_seen, exp_reads);
        for (int k = 0; k < 4; k++) send(77, 0, 1'b0);
        check("held_data_newest", int'(data[DEPTH-1]), 1383);
        check("held_data_trig", int'(data[PRETRIG]), 1000);
        ready = 1'b0; tick();
        check("held_data_copying", int'(data[DEPTH-1]), 1383);
        trig_enable = 1'b0; ready = 1'b1;
        tick(); tick();
        check("held_idle", int'(busy), 0);

        // Asynchronous reset in mid-POST, then a clean recapture.
        trig_enable = 1'b1; tick();
        send_ramp(0, 1100, 0, -1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_read", int'(read), 0);
        check("arst_data_nonzero", count_nonzero(), 0);
        @(negedge clk) rst = 1'b0;
        tick();
        exp_q.push_back(1000 - PRETRIG); exp_reads++;
        send_ramp(0, 1500, 0, -1);
        check("arst_recap_reads", reads_seen, exp_reads);
        finish_copy();

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
